// File: rtl/mux_probe_pkg.sv
// ============================================================================
// Package : mux_probe_pkg
// Purpose : Shared constants for the 2:1 mux probe sweeper. This package holds
//           the probe width, the FSM state encoding and the bit positions of
//           each wire in the probe vector.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package mux_probe_pkg;

  // Width of the wire-state vector returned by the mux.
  localparam int PROBE_W = 9;

  typedef logic [1:0] state_t;
  typedef logic [2:0] code_t;

  // Sweeper FSM encoding.
  localparam state_t IDLE  = 2'd0;
  localparam state_t WAIT  = 2'd1;
  localparam state_t CHECK = 2'd2;
  localparam state_t DONE  = 2'd3;

  // Wire map of the probe vector.
  localparam int P_I0   = 0;  // I0 input wire
  localparam int P_I1   = 1;  // I1 input wire
  localparam int P_S0   = 2;  // S fan-out branch 0
  localparam int P_S1   = 3;  // S fan-out branch 1
  localparam int P_S2   = 4;  // S fan-out branch 2
  localparam int P_SN   = 5;  // inverted select
  localparam int P_A1   = 6;  // AND term I1 & S
  localparam int P_A0   = 7;  // AND term I0 & ~S
  localparam int P_RSVD = 8;  // reserved, must read 0

endpackage : mux_probe_pkg

`default_nettype wire

// File: rtl/mux_probe_expect.sv
// ============================================================================
// Module  : mux_probe_expect
// Purpose : Combinational model of the wire states a healthy 2:1 mux shows
//           for a given input code {S,I1,I0}.
// Ports   : code_i [2:0]        input code, S = code_i[2]
//           exp_o  [PROBE_W-1:0] expected probe vector
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mux_probe_expect
  import mux_probe_pkg::*;
(
  input  logic [2:0]         code_i,
  output logic [PROBE_W-1:0] exp_o
);

  logic w_s;
  logic w_i1;
  logic w_i0;

  assign w_s  = code_i[2];
  assign w_i1 = code_i[1];
  assign w_i0 = code_i[0];

  always_comb begin
    exp_o         = '0;
    exp_o[P_I0]   = w_i0;
    exp_o[P_I1]   = w_i1;
    exp_o[P_S0]   = w_s;
    exp_o[P_S1]   = w_s;
    exp_o[P_S2]   = w_s;
    exp_o[P_SN]   = ~w_s;
    exp_o[P_A1]   = w_i1 & w_s;
    exp_o[P_A0]   = w_i0 & ~w_s;
    exp_o[P_RSVD] = 1'b0;
  end

endmodule : mux_probe_expect

`default_nettype wire

// File: rtl/mux_probe_sweeper.sv
// ============================================================================
// Module  : mux_probe_sweeper
// Purpose : Walks all 8 input codes {S,I1,I0} onto a 2:1 mux, waits SETTLE
//           cycles per code, then checks the returned probe vector against the
//           expected wire states and records the decoded mux output.
// Ports   : clk, rst        clock / asynchronous active-high reset
//           start           sweep request (honoured in IDLE or DONE only)
//           probe_in        wire-state vector from the mux
//           s_out/i1_out/i0_out  registered drive of the current code
//           busy            high in WAIT or CHECK
//           done            high in DONE
//           pass            done with no mismatching code
//           fail_mask[7:0]  bit c set when code c mismatched
//           mux_y[7:0]      bit c = mux output observed for code c
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mux_probe_sweeper
  import mux_probe_pkg::*;
#(
  parameter int unsigned SETTLE = 2   // legal range 1..15
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [PROBE_W-1:0] probe_in,
  output logic               s_out,
  output logic               i1_out,
  output logic               i0_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [7:0]         fail_mask,
  output logic [7:0]         mux_y
);

  // WAIT is left once the counter shows SETTLE-1, giving SETTLE cycles in WAIT.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t             state_q, state_d;
  code_t              code_q,  code_d;
  logic [3:0]         cnt_q,   cnt_d;
  logic [7:0]         fail_q,  fail_d;
  logic [7:0]         muxy_q,  muxy_d;
  code_t              drv_q,   drv_d;
  logic [PROBE_W-1:0] exp_w;
  logic               launch_w;

  mux_probe_expect u_expect (
    .code_i (code_q),
    .exp_o  (exp_w)
  );

  assign launch_w = ((state_q == IDLE) || (state_q == DONE)) && start;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= '0;
      cnt_q   <= '0;
      fail_q  <= '0;
      muxy_q  <= '0;
      drv_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      muxy_q  <= muxy_d;
      drv_q   <= drv_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = WAIT;
      WAIT:       if (cnt_q == SETTLE_LAST) state_d = CHECK;
      CHECK:      state_d = (code_q == 3'd7) ? DONE : WAIT;
      default:    state_d = IDLE;
    endcase
  end

  // Datapath next values: counter, code and result capture.
  always_comb begin
    code_d = code_q;
    cnt_d  = cnt_q;
    fail_d = fail_q;
    muxy_d = muxy_q;
    if (launch_w) begin
      code_d = '0;
      cnt_d  = '0;
      fail_d = '0;
      muxy_d = '0;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q + 4'd1;
    end else if (state_q == CHECK) begin
      // Exact compare: X/Z on the probe propagates into the mask bit.
      fail_d[code_q] = (probe_in != exp_w);
      muxy_d[code_q] = probe_in[P_A1] | probe_in[P_A0];
      if (code_q != 3'd7) begin
        code_d = code_q + 3'd1;
        cnt_d  = '0;
      end
    end
    // Mux drive only moves on the edge that enters WAIT, so the mux inputs
    // stay stable through the whole settle and check window.
    drv_d = ((state_d == WAIT) && (state_q != WAIT)) ? code_d : drv_q;
  end

  // Outputs.
  always_comb begin
    busy      = (state_q == WAIT) || (state_q == CHECK);
    done      = (state_q == DONE);
    pass      = done && (fail_q == 8'h00);
    fail_mask = fail_q;
    mux_y     = muxy_q;
    s_out     = drv_q[2];
    i1_out    = drv_q[1];
    i0_out    = drv_q[0];
  end

endmodule : mux_probe_sweeper

`default_nettype wire

// File: tb/tb_mux_probe_sweeper.sv
// ============================================================================
// Module  : tb_mux_probe_sweeper
// Purpose : Self-checking bench for mux_probe_sweeper. Instance A uses
//           SETTLE=2, instance B uses SETTLE=1; each is wired to a behavioural
//           2:1 mux whose probe bits can be forced high or low.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mux_probe_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_a, start_b;
  logic [8:0] set_a, clr_a, set_b, clr_b;

  logic [8:0] probe_a, probe_b;
  logic       s_a, i1_a, i0_a, busy_a, done_a, pass_a;
  logic       s_b, i1_b, i0_b, busy_b, done_b, pass_b;
  logic [7:0] fm_a, my_a, fm_b, my_b;

  // Healthy 2:1 mux wire states: {rsvd, I0&~S, I1&S, ~S, S, S, S, I1, I0}.
  function automatic logic [8:0] mux_wires(input logic s, input logic i1, input logic i0);
    return {1'b0, i0 & ~s, i1 & s, ~s, s, s, s, i1, i0};
  endfunction

  assign probe_a = (mux_wires(s_a, i1_a, i0_a) | set_a) & ~clr_a;
  assign probe_b = (mux_wires(s_b, i1_b, i0_b) | set_b) & ~clr_b;

  mux_probe_sweeper #(.SETTLE(2)) dut_a (
    .clk (clk), .rst (rst), .start (start_a), .probe_in (probe_a),
    .s_out (s_a), .i1_out (i1_a), .i0_out (i0_a),
    .busy (busy_a), .done (done_a), .pass (pass_a),
    .fail_mask (fm_a), .mux_y (my_a)
  );

  mux_probe_sweeper #(.SETTLE(1)) dut_b (
    .clk (clk), .rst (rst), .start (start_b), .probe_in (probe_b),
    .s_out (s_b), .i1_out (i1_b), .i0_out (i0_b),
    .busy (busy_b), .done (done_b), .pass (pass_b),
    .fail_mask (fm_b), .mux_y (my_b)
  );

  typedef struct {
    logic [7:0] fm;
    logic [7:0] my;
    logic       pass;
    int         done_edge;
    int         busy_cycles;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_run++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] fm, input logic [7:0] my, input logic p,
                      input int de, input int bc);
    exp_t e;
    e.fm = fm; e.my = my; e.pass = p; e.done_edge = de; e.busy_cycles = bc;
    sb.push_back(e);
  endtask

  // Runs one sweep on instance A; edge 1 is the edge that samples start.
  // Extra start pulses are presented to the edges numbered p1 and p2.
  task automatic sweep_a(input string tag, input int p1, input int p2);
    int   edges;
    int   busy_cycles;
    exp_t e;
    edges       = 0;
    busy_cycles = 0;
    start_a = 1'b1;
    tick();
    edges   = 1;
    start_a = 1'b0;
    while (!done_a && edges < 60) begin
      if (busy_a) busy_cycles++;
      start_a = ((edges + 1) == p1) || ((edges + 1) == p2);
      tick();
      edges++;
    end
    start_a = 1'b0;
    if (sb.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_done"},      {31'd0, done_a}, 32'd1);
      check({tag, "_done_edge"}, edges, e.done_edge);
      check({tag, "_busy_cyc"},  busy_cycles, e.busy_cycles);
      check({tag, "_fail_mask"}, {24'd0, fm_a}, {24'd0, e.fm});
      check({tag, "_mux_y"},     {24'd0, my_a}, {24'd0, e.my});
      check({tag, "_pass"},      {31'd0, pass_a}, {31'd0, e.pass});
    end
  endtask

  initial begin
    int edges;
    exp_t e;
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    set_a = '0; clr_a = '0; set_b = '0; clr_b = '0;
    #1;
    check("reset_outs_a", {22'd0, busy_a, done_a, pass_a, s_a, i1_a, i0_a, fm_a, my_a}, 32'd0);
    check("reset_outs_b", {22'd0, busy_b, done_b, pass_b, s_b, i1_b, i0_b, fm_b, my_b}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("idle_no_busy", {30'd0, busy_a, done_a}, 32'd0);

    // 1: healthy mux.
    push(8'h00, 8'hCA, 1'b1, 25, 24);
    sweep_a("t1", 0, 0);
    check("t1_drive_last_code", {29'd0, s_a, i1_a, i0_a}, 32'd7);

    // 2: reserved bit forced high, restart straight from DONE.
    set_a = 9'h100;
    push(8'hFF, 8'hCA, 1'b0, 25, 24);
    sweep_a("t2", 0, 0);
    set_a = '0;

    // 3: inverted-select wire stuck low -> codes with S=0 fail.
    clr_a = 9'h020;
    push(8'h0F, 8'hCA, 1'b0, 25, 24);
    sweep_a("t3", 0, 0);
    clr_a = '0;

    // 4: start pulses while busy are ignored.
    push(8'h00, 8'hCA, 1'b1, 25, 24);
    sweep_a("t4", 5, 12);

    // 5: asynchronous reset during the CHECK of code 3.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (11) tick();
    check("t5_busy_in_check", {31'd0, busy_a}, 32'd1);
    check("t5_drive_code3", {29'd0, s_a, i1_a, i0_a}, 32'd3);
    check("t5_partial_mux_y", {24'd0, my_a}, 32'h02);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_clear", {22'd0, busy_a, done_a, pass_a, s_a, i1_a, i0_a, fm_a, my_a}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    push(8'h00, 8'hCA, 1'b1, 25, 24);
    sweep_a("t5_clean", 0, 0);

    // 6: SETTLE=1 with start held high and a forced reserved bit.
    set_b = 9'h100;
    push(8'hFF, 8'hCA, 1'b0, 17, 0);
    start_b = 1'b1;
    tick();
    edges = 1;
    while (!done_b && edges < 60) begin
      tick();
      edges++;
    end
    e = sb.pop_front();
    check("t6_done", {31'd0, done_b}, 32'd1);
    check("t6_done_edge", edges, e.done_edge);
    check("t6_fail_mask", {24'd0, fm_b}, {24'd0, e.fm});
    check("t6_mux_y", {24'd0, my_b}, {24'd0, e.my});
    check("t6_pass", {31'd0, pass_b}, {31'd0, e.pass});
    tick();
    check("t6_restart_done_low", {31'd0, done_b}, 32'd0);
    check("t6_restart_busy", {31'd0, busy_b}, 32'd1);
    check("t6_restart_clear", {16'd0, fm_b, my_b}, 32'd0);
    check("t6_restart_drive", {29'd0, s_b, i1_b, i0_b}, 32'd0);
    start_b = 1'b0;
    set_b = '0;
    tick();
    rst = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule : tb_mux_probe_sweeper

`default_nettype wire
